// File: rtl/rx_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_resp_pkg
// Purpose  : Shared constants, index-width helper and response record layout
// Revision : 1.0
// ============================================================================
package rx_resp_pkg;

    localparam int OP_ID_W     = 8;
    localparam int IDX_W_MAX   = 8;
    localparam int DATA_W_MAX  = 32;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Widest record layout; the collector packs only the bits its
    // parameters need into the response queue.
    typedef struct packed {
        logic [OP_ID_W-1:0]    op_id;
        logic [IDX_W_MAX-1:0]  idx;
        logic                  is_wr;
        logic [DATA_W_MAX-1:0] data;
    } resp_t;

endpackage
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : resp_fifo
// Purpose  : Power-of-two response queue, no bypass, head reads 0 when empty
// Revision : 1.0
// ============================================================================
module resp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = empty ? '0 : r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_pop     = pop & ~empty;
    assign w_push    = push & (~full | w_pop);
    assign overflow  = push & full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rx_resp_collector.sv
`default_nettype none
// ============================================================================
// Module   : rx_resp_collector
// Purpose  : Tracks switch accesses, queues ordered responses; RX_WR_ACK_EN adds write acks
// Revision : 1.0
// ============================================================================
module rx_resp_collector
    import rx_resp_pkg::*;
#(
    parameter  int NUM_SW_INST = 5,
    parameter  int W_WIDTH     = 8,
    parameter  int RD_LAT      = 2,
    parameter  int RESP_DEPTH  = 4,
    localparam int IDX_W       = idx_w(NUM_SW_INST),
    localparam int CNT_W       = $clog2(RESP_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SW_INST-1:0]         sel_en_in,
    input  logic [NUM_SW_INST*OP_ID_W-1:0] op_id_in,
    input  logic                           wr_rd_s,
    input  logic [W_WIDTH-1:0]             rd_data,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [OP_ID_W-1:0]             resp_op_id,
    output logic [IDX_W-1:0]               resp_inst,
    output logic                           resp_is_wr,
    output logic [W_WIDTH-1:0]             resp_data,
    output logic [CNT_W-1:0]               resp_count,
    output logic                           stall_out,
    input  logic                           clr_err,
    output logic                           overflow_err,
    output logic                           protocol_err
);

    localparam int REC_W = OP_ID_W + IDX_W + 1 + W_WIDTH;
    localparam int AL    = RD_LAT - 1;

    logic [IDX_W-1:0]   w_sel_idx;
    logic [OP_ID_W-1:0] w_sel_op;
    logic               w_sel_any;
    logic               w_sel_multi;
    logic               w_issue;

    logic               r_pv   [RD_LAT];
    logic [OP_ID_W-1:0] r_pop  [RD_LAT];
    logic [IDX_W-1:0]   r_pidx [RD_LAT];
    logic               r_pwr  [RD_LAT];

    logic [31:0]        w_inflight;
    logic               w_push;
    logic               w_rec_wr;
    logic [REC_W-1:0]   w_push_rec;
    logic [REC_W-1:0]   w_head;
    logic               w_empty;
    logic               w_full;
    logic               w_overflow;
    logic               r_overflow_err;
    logic               r_protocol_err;

    always_comb begin
        w_sel_idx = '0;
        w_sel_op  = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (sel_en_in[i]) begin
                w_sel_idx = IDX_W'(i);
                w_sel_op  = op_id_in[i*OP_ID_W +: OP_ID_W];
            end
        end
    end

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_sel_any   = |sel_en_in;
    assign w_sel_multi = |(sel_en_in & (sel_en_in - NUM_SW_INST'(1)));
    assign w_issue     = w_sel_any & ~w_sel_multi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_pv[s] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_issue;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pop[0]  <= w_sel_op;
        r_pidx[0] <= w_sel_idx;
        r_pwr[0]  <= wr_rd_s;
        for (int s = 1; s < RD_LAT; s++) begin
            r_pop[s]  <= r_pop[s-1];
            r_pidx[s] <= r_pidx[s-1];
            r_pwr[s]  <= r_pwr[s-1];
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int s = 0; s < RD_LAT; s++) begin
            w_inflight = w_inflight + 32'(r_pv[s]);
        end
    end

    assign stall_out = (32'(resp_count) + w_inflight) >= 32'(RESP_DEPTH);

`ifdef RX_WR_ACK_EN
    assign w_push   = r_pv[AL];
    assign w_rec_wr = r_pwr[AL];
`else
    // Writes still occupy a stage for stall accounting but never queue.
    assign w_push   = r_pv[AL] & ~r_pwr[AL];
    assign w_rec_wr = 1'b0;
`endif

    assign w_push_rec = {r_pop[AL], r_pidx[AL], w_rec_wr,
                         (r_pwr[AL] ? '0 : rd_data)};

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (REC_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_rec),
        .pop       (resp_ready),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (resp_count),
        .overflow  (w_overflow)
    );

    assign resp_valid = ~w_empty;
    assign {resp_op_id, resp_inst, resp_is_wr, resp_data} = w_head;

    // A new error event in a clearing cycle must win over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow_err <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_overflow_err <= (r_overflow_err & ~clr_err) | (w_overflow & ~(w_full & 1'b0));
            r_protocol_err <= (r_protocol_err & ~clr_err) | w_sel_multi;
        end
    end

    assign overflow_err = r_overflow_err;
    assign protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_rx_resp_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_resp_collector
// Purpose  : Directed bench with queue-level response model; honours RX_WR_ACK_EN
// Revision : 1.0
// ============================================================================
module tb_rx_resp_collector;

    localparam int N = 5;
    localparam int W = 8;
    localparam int L = 2;
    localparam int D = 4;
`ifdef RX_WR_ACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   sel_en_in;
    logic [N*8-1:0] op_id_in;
    logic           wr_rd_s;
    logic [W-1:0]   rd_data;
    logic           resp_ready;
    logic           clr_err;
    logic           resp_valid;
    logic [7:0]     resp_op_id;
    logic [2:0]     resp_inst;
    logic           resp_is_wr;
    logic [W-1:0]   resp_data;
    logic [2:0]     resp_count;
    logic           stall_out;
    logic           overflow_err;
    logic           protocol_err;

    always #5 clk = ~clk;

    rx_resp_collector #(
        .NUM_SW_INST (N),
        .W_WIDTH     (W),
        .RD_LAT      (L),
        .RESP_DEPTH  (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sel_en_in    (sel_en_in),
        .op_id_in     (op_id_in),
        .wr_rd_s      (wr_rd_s),
        .rd_data      (rd_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_op_id   (resp_op_id),
        .resp_inst    (resp_inst),
        .resp_is_wr   (resp_is_wr),
        .resp_data    (resp_data),
        .resp_count   (resp_count),
        .stall_out    (stall_out),
        .clr_err      (clr_err),
        .overflow_err (overflow_err),
        .protocol_err (protocol_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] op;
        int         idx;
        logic       wr;
        logic [7:0] data;
    } rec_t;

    typedef struct {
        int         rem;
        logic [7:0] op;
        int         idx;
        logic       wr;
    } pend_t;

    rec_t  mq[$];
    pend_t pq[$];
    bit    m_prot;
    bit    m_ovf;
    bit    started = 1'b0;
    bit    m_pop;
    bit    m_full;
    bit    m_ovf_ev;
    pend_t m_p;
    rec_t  m_r;
    int    m_ones;

    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            pq.delete();
            m_prot  = 1'b0;
            m_ovf   = 1'b0;
            started = 1'b1;
        end else begin
            m_pop    = (mq.size() != 0) && (resp_ready == 1'b1);
            m_full   = (mq.size() == D);
            m_ovf_ev = 1'b0;
            if (m_pop) void'(mq.pop_front());
            foreach (pq[i]) pq[i].rem = pq[i].rem - 1;
            if (pq.size() != 0 && pq[0].rem == 0) begin
                m_p = pq.pop_front();
                if (!m_p.wr || WRACK) begin
                    if (m_full && !m_pop) m_ovf_ev = 1'b1;
                    else begin
                        m_r.op   = m_p.op;
                        m_r.idx  = m_p.idx;
                        m_r.wr   = m_p.wr;
                        m_r.data = m_p.wr ? 8'h00 : rd_data;
                        mq.push_back(m_r);
                    end
                end
            end
            m_ones = $countones(sel_en_in);
            if (m_ones == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (sel_en_in[i]) begin
                        m_p.idx = i;
                        m_p.op  = op_id_in[i*8 +: 8];
                    end
                end
                m_p.rem = L;
                m_p.wr  = wr_rd_s;
                pq.push_back(m_p);
            end
            m_prot = (m_prot && !clr_err) || (m_ones > 1);
            m_ovf  = (m_ovf && !clr_err) || m_ovf_ev;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("resp_valid", 32'(resp_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("resp_op_id", 32'(resp_op_id), 32'(mq[0].op));
                chk("resp_inst",  32'(resp_inst),  32'(mq[0].idx));
                chk("resp_is_wr", 32'(resp_is_wr), 32'(mq[0].wr));
                chk("resp_data",  32'(resp_data),  32'(mq[0].data));
            end else begin
                chk("resp_op_id_empty", 32'(resp_op_id), 32'd0);
                chk("resp_inst_empty",  32'(resp_inst),  32'd0);
                chk("resp_data_empty",  32'(resp_data),  32'd0);
            end
            chk("resp_count",   32'(resp_count),   32'(mq.size()));
            chk("stall_out",    32'(stall_out),    32'((mq.size() + pq.size()) >= D));
            chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
            chk("protocol_err", 32'(protocol_err), 32'(m_prot));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [N-1:0] sel, input logic [7:0] op, input logic wr,
                         input logic [7:0] rd, input logic rdy, input logic clr);
        sel_en_in = sel;
        for (int i = 0; i < N; i++) op_id_in[i*8 +: 8] = sel[i] ? op : ~op;
        wr_rd_s    = wr;
        rd_data    = rd;
        resp_ready = rdy;
        clr_err    = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive('0, 8'h00, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    int issued;

    initial begin
        rst_n = 1'b0;
        idle(2, 1'b0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_count", 32'(resp_count), 32'd0);
        chk("rst_stall", 32'(stall_out), 32'd0);
        chk("rst_errs",  32'({overflow_err, protocol_err}), 32'd0);
        rst_n = 1'b1;

        // single read
        drive(5'b00100, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        drive('0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        drive('0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("rd_valid", 32'(resp_valid), 32'd1);
        chk("rd_op",    32'(resp_op_id), 32'h3C);
        chk("rd_inst",  32'(resp_inst),  32'd2);
        chk("rd_iswr",  32'(resp_is_wr), 32'd0);
        chk("rd_data",  32'(resp_data),  32'hA5);
        drive('0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rd_popped", 32'(resp_valid), 32'd0);

        // backpressure: issue only while stall is low
        issued = 0;
        for (int k = 0; k < 8; k++) begin
            if (!stall_out) begin
                drive(N'(1) << (k % N), 8'(8'h10 + k), 1'b0, 8'(8'h50 + k), 1'b0, 1'b0);
                issued++;
            end else begin
                drive('0, 8'h00, 1'b0, 8'(8'h50 + k), 1'b0, 1'b0);
            end
        end
        chk("bp_issued", 32'(issued), 32'd4);
        chk("bp_count",  32'(resp_count), 32'd4);
        chk("bp_stall",  32'(stall_out), 32'd1);
        chk("bp_head",   32'(resp_op_id), 32'h10);
        drive(5'b01000, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("ovf_set",   32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(resp_count), 32'd4);

        // full queue: push and pop on the same edge
        drive('0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow_err), 32'd0);
        drive(5'b00010, 8'hC1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive('0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        drive('0, 8'h00, 1'b0, 8'hEE, 1'b1, 1'b0);
        chk("pp_count", 32'(resp_count), 32'd4);
        chk("pp_noovf", 32'(overflow_err), 32'd0);
        chk("pp_head",  32'(resp_op_id), 32'h11);
        idle(3, 1'b1);
        chk("pp_last_op",   32'(resp_op_id), 32'hC1);
        chk("pp_last_data", 32'(resp_data),  32'hEE);
        idle(1, 1'b1);
        chk("pp_drained", 32'(resp_count), 32'd0);

        // multi-hot select
        drive(5'b00011, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("mh_prot", 32'(protocol_err), 32'd1);
        idle(3, 1'b0);
        chk("mh_noresp", 32'(resp_valid), 32'd0);
        drive('0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("mh_clr", 32'(protocol_err), 32'd0);
        drive(5'b00110, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("mh_clr_vs_set", 32'(protocol_err), 32'd1);
        drive('0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        idle(3, 1'b0);

        // write access
        drive(5'b10000, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("wr_stall_acct", 32'(dut.w_inflight), 32'd1);
        idle(2, 1'b0);
`ifdef RX_WR_ACK_EN
        chk("wr_valid", 32'(resp_valid), 32'd1);
        chk("wr_inst",  32'(resp_inst),  32'd4);
        chk("wr_iswr",  32'(resp_is_wr), 32'd1);
        chk("wr_data",  32'(resp_data),  32'd0);
        chk("wr_op",    32'(resp_op_id), 32'h7F);
`else
        chk("wr_noresp", 32'(resp_valid), 32'd0);
        chk("wr_count",  32'(resp_count), 32'd0);
`endif
        idle(2, 1'b1);

        // reset with accesses in flight
        drive(5'b00001, 8'hA1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(5'b00010, 8'hA2, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        drive('0, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0);
        chk("mr_valid", 32'(resp_valid), 32'd0);
        chk("mr_count", 32'(resp_count), 32'd0);
        chk("mr_stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;
        drive('0, 8'h00, 1'b0, 8'h44, 1'b0, 1'b0);
        idle(4, 1'b0);
        chk("mr_noresp", 32'(resp_valid), 32'd0);
        chk("mr_count2", 32'(resp_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
